// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for a 0x7E sync byte, checks a length-prefixed, checksummed frame into a
// local buffer and releases its payload as a valid/ready stream. Define UART_FRAME_TIMEOUT_EN for an inter-byte timeout.
module uart_frame_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_recv,
  input  logic       in_err,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
  localparam int unsigned ADR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  SYNC     = 8'h7E;
  localparam logic [1:0]  CODE_RX  = 2'd0;
  localparam logic [1:0]  CODE_LEN = 2'd1;
  localparam logic [1:0]  CODE_CK  = 2'd2;
  localparam logic [1:0]  CODE_TO  = 2'd3;

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("uart_frame_rx: MAX_LEN must be 1..255");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_frame_rx: TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_EMIT
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] len, len_d;
  logic [IDX_W-1:0] wr_idx, wr_idx_d;
  logic [IDX_W-1:0] rd_idx, rd_idx_d;
  logic [IDX_W-1:0] last_idx_c;
  logic [IDX_W-1:0] rd_nxt_c;
  logic [7:0]       sum, sum_d;
  logic [7:0]       mem [MAX_LEN];
  logic             mem_we_c;
  logic             timeout_c;

  logic             out_valid_d, out_last_d, frame_ok_d, frame_err_d, drop_d;
  logic [7:0]       out_data_d;
  logic [1:0]       err_code_d;

  assign last_idx_c = len - IDX_W'(1);
  assign rd_nxt_c   = rd_idx + IDX_W'(1);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             in_frame_c;

  assign in_frame_c = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CKSUM);

  // Idle cycles since the last byte of the frame in progress; parked at zero outside a frame.
  always_ff @(posedge clk) begin
    if (rst || !in_frame_c || in_recv || in_err) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + CNT_W'(1);
  end

  // Fires so that frame_err lands exactly TIMEOUT cycles after the last byte strobe.
  assign timeout_c = in_frame_c && (idle_cnt == CNT_W'(TIMEOUT - 2));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      wr_idx    <= wr_idx_d;
      rd_idx    <= rd_idx_d;
      sum       <= sum_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      drop      <= drop_d;
    end
  end

  // Payload buffer; contents survive reset and are only trusted after a checksum pass.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wr_idx[ADR_W-1:0]] <= in_data;
  end

  always_comb begin
    state_d     = state;
    len_d       = len;
    wr_idx_d    = wr_idx;
    rd_idx_d    = rd_idx;
    sum_d       = sum;
    mem_we_c    = 1'b0;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    drop_d      = 1'b0;

    unique case (state)
      ST_HUNT: begin
        if (in_recv && (in_data == SYNC)) state_d = ST_LEN;
      end

      ST_LEN, ST_PAYLOAD, ST_CKSUM: begin
        // A receiver error wins over a byte strobed in the same cycle.
        if (in_err) begin
          frame_err_d = 1'b1;
          err_code_d  = CODE_RX;
          state_d     = ST_HUNT;
        end else if (in_recv) begin
          if (state == ST_LEN) begin
            if ((in_data == 8'd0) || (in_data > 8'(MAX_LEN))) begin
              frame_err_d = 1'b1;
              err_code_d  = CODE_LEN;
              state_d     = ST_HUNT;
            end else begin
              len_d    = IDX_W'(in_data);
              sum_d    = in_data;
              wr_idx_d = '0;
              state_d  = ST_PAYLOAD;
            end
          end else if (state == ST_PAYLOAD) begin
            mem_we_c = 1'b1;
            sum_d    = sum + in_data;
            wr_idx_d = wr_idx + IDX_W'(1);
            if (wr_idx == last_idx_c) state_d = ST_CKSUM;
          end else begin
            if (8'(sum + in_data) == 8'd0) begin
              frame_ok_d  = 1'b1;
              rd_idx_d    = '0;
              out_valid_d = 1'b1;
              out_data_d  = mem[ADR_W'(0)];
              out_last_d  = (len == IDX_W'(1));
              state_d     = ST_EMIT;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = CODE_CK;
              state_d     = ST_HUNT;
            end
          end
        end else if (timeout_c) begin
          frame_err_d = 1'b1;
          err_code_d  = CODE_TO;
          state_d     = ST_HUNT;
        end
      end

      ST_EMIT: begin
        // Bytes arriving while the buffer drains are lost, sync bytes included.
        drop_d = in_recv;
        if (out_ready) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            state_d     = ST_HUNT;
          end else begin
            rd_idx_d   = rd_nxt_c;
            out_data_d = mem[rd_nxt_c[ADR_W-1:0]];
            out_last_d = (rd_nxt_c == last_idx_c);
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-to-frame stage directly downstream of the UART receiver. Consumes the receiver's one-cycle `recv`/`err`/`data` byte strobes, hunts for a sync byte, checks a length-prefixed, checksummed frame into an internal buffer, and releases the payload as a valid/ready byte stream only after the checksum passes. Bad frames are discarded whole and reported with an error code.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame; legal range 1..255.
- `TIMEOUT`, 100000: maximum clk cycles between bytes inside a frame (see Configuration).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_recv` in 1: one-cycle strobe; `in_data` holds a received byte.
- `in_err` in 1: one-cycle strobe; receiver stop-bit error.
- `in_data` in 8: received byte, valid when `in_recv`=1.
- `out_valid` out 1: payload byte available.
- `out_ready` in 1: consumer accepts byte when `out_valid`&&`out_ready`.
- `out_data` out 8: payload byte.
- `out_last` out 1: final payload byte of frame; qualified by `out_valid`.
- `frame_ok` out 1: one-cycle pulse; frame passed checks.
- `frame_err` out 1: one-cycle pulse; frame discarded.
- `err_code` out 2: 0 receiver error, 1 bad length, 2 checksum, 3 timeout. Updated on each `frame_err`, held otherwise.
- `drop` out 1: one-cycle pulse; byte arrived during EMIT and was discarded.

## Operation
- Frame format: 0x7E, LEN, LEN payload bytes, CK. Valid iff (LEN + sum(payload) + CK) mod 256 == 0. Running sum is 8-bit, wraps.
- States: HUNT, LEN, PAYLOAD, CKSUM, EMIT.
- HUNT: `in_recv` with 0x7E -> LEN; any other byte and `in_err` ignored, no error reported.
- LEN: byte 0 or >MAX_LEN -> `frame_err`, code 1, HUNT. Else latch len, sum<=byte, wr_idx<=0 -> PAYLOAD. A 0x7E here is a length byte, not resync.
- PAYLOAD: each byte written to buf[wr_idx], sum+=byte, wr_idx++; byte at wr_idx==len-1 -> CKSUM.
- CKSUM: sum+byte==0 -> `frame_ok`, rd_idx<=0, EMIT. Else `frame_err`, code 2, HUNT.
- `in_err` in LEN/PAYLOAD/CKSUM -> `frame_err`, code 0, HUNT. Takes priority over `in_recv` same cycle.
- EMIT: `out_valid`=1, `out_data`=buf[rd_idx], `out_last`=(rd_idx==len-1). Handshake -> rd_idx++; handshake with `out_last` -> HUNT. Any `in_recv` in EMIT -> `drop` pulse, byte lost (including 0x7E); `in_err` ignored.
- Index widths: clog2(MAX_LEN+1) bits; buffer is MAX_LEN x 8.

## Timing
- Reset: state HUNT; `out_valid`, `out_last`, `frame_ok`, `frame_err`, `drop` = 0; `err_code` = 0; `out_data` = 0 while `out_valid`=0. Buffer contents not cleared.
- Reset mid-frame or mid-EMIT: frame abandoned, no pulse, next cycle in HUNT.
- All outputs registered. CK strobe at cycle N -> `frame_ok` and `out_valid` high at N+1.
- `frame_err` appears the cycle after the offending strobe/timeout.
- `out_data`/`out_last` stable while `out_valid`&&!`out_ready`; `out_valid` never drops without handshake.
- Back-to-back emit: with `out_ready` held 1, one byte per cycle; LEN-byte frame emits in LEN cycles.
- After last handshake, HUNT next cycle; a 0x7E arriving that same handshake cycle is dropped.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined: cycle counter reset on every accepted byte in LEN/PAYLOAD/CKSUM; reaching TIMEOUT cycles with no byte -> `frame_err`, code 3, HUNT. Counter idle in HUNT and EMIT.
- Not defined: no counter; a stalled frame waits indefinitely; code 3 never produced.

## Test plan
- Bytes 7E 03 11 22 33 97 -> `frame_ok` once; stream 11,22,33 with `out_last` only on 33; no `frame_err`.
- Same frame, CK=98 -> `frame_err`, `err_code`=2, no `out_valid`; next good frame accepted.
- 7E 00 and 7E 11 (MAX_LEN=16) -> `frame_err` code 1 each; 7E 10 + 16 bytes + correct CK -> 16 bytes emitted.
- 7E 02 AA then `in_err` -> `frame_err` code 0; junk 55 AA before 7E in HUNT -> ignored, no pulses.
- Good frame with `out_ready` low 5 cycles, then toggling; 2 bytes sent during EMIT -> data held stable, 2 `drop` pulses, order preserved.
- With `UART_FRAME_TIMEOUT_EN`, TIMEOUT=50: 7E 02 AA then idle -> `frame_err` code 3 exactly 50 cycles after AA; `rst` pulse mid-PAYLOAD -> all outputs 0, HUNT.
